// File: rtl/hex_display_ctrl_pkg.sv
// Shared constants for the hex display controller.
//   - Avalon-MM register word addresses
//   - CTRL register bit positions
//   - Hex glyph table, active-high, bit0 = segment a, bit6 = segment g
package hex_display_pkg;

    localparam logic [3:0] ADDR_DATA     = 4'd0;
    localparam logic [3:0] ADDR_DP       = 4'd1;
    localparam logic [3:0] ADDR_BLANK    = 4'd2;
    localparam logic [3:0] ADDR_BLINK    = 4'd3;
    localparam logic [3:0] ADDR_CTRL     = 4'd4;
    localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

    localparam int CTRL_MODE_BIT    = 0;
    localparam int CTRL_RESTART_BIT = 1;
    localparam int CTRL_PHASE_BIT   = 8;

    // Ascending range so entry 0 is the leftmost element of the concatenation.
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Avalon-MM slave bus bundle for the hex display controller.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : read data, zero wait / zero latency
interface hex_display_ctrl_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_display_ctrl_seg_decode.sv
// Combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit value 0..F
//   seg    : active-high segments, bit0 = a .. bit6 = g
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM seven-segment display controller for up to 8 digits.
// Per-digit hex decode or raw segments, decimal points, blanking and blink.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   out_port     : digit i in [8i+7:8i], bit7 = DP, bits 6:0 = g..a; registered
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    hex_display_ctrl_if.slave       bus,
    output logic [NUM_DIGITS*8-1:0] out_port
);
    localparam int N  = NUM_DIGITS;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [N*8-1:0] DARK     = {N*8{ACTIVE_LOW}};

    logic [4*N-1:0]      data_q, data_d;
    logic [N-1:0]        dp_q, dp_d;
    logic [N-1:0]        blank_q, blank_d;
    logic [N-1:0]        blink_q, blink_d;
    logic                mode_q, mode_d;
    logic [N-1:0][7:0]   raw_q, raw_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [N*8-1:0]      out_q, out_d;
    logic [N-1:0][6:0]   seg;
    logic                wr_en, restart;
    logic [31:0]         rd_data;
    logic                unused_wdata;

    assign wr_en = bus.chipselect && !bus.write_n;

    // Write-data bits above a register's field are simply dropped.
    assign unused_wdata = ^bus.writedata;

    // Register writes; unmapped addresses fall through with no effect.
    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        blink_d = blink_q;
        mode_d  = mode_q;
        raw_d   = raw_q;
        restart = 1'b0;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:  data_d  = bus.writedata[4*N-1:0];
                ADDR_DP:    dp_d    = bus.writedata[N-1:0];
                ADDR_BLANK: blank_d = bus.writedata[N-1:0];
                ADDR_BLINK: blink_d = bus.writedata[N-1:0];
                ADDR_CTRL: begin
                    mode_d  = bus.writedata[CTRL_MODE_BIT];
                    restart = bus.writedata[CTRL_RESTART_BIT];
                end
                default: begin
                    for (int i = 0; i < N; i++)
                        if (bus.address == 4'(ADDR_RAW_BASE + i))
                            raw_d[i] = bus.writedata[7:0];
                end
            endcase
        end
    end

    // Blink prescaler; RESTART wins over a wrap in the same cycle.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Output bytes come from the current register state, so a write shows
    // on the pins one edge after it lands.
    for (genvar i = 0; i < N; i++) begin : g_digit
        logic [7:0] lit;
        hex_seg_decode u_dec (.nibble(data_q[4*i +: 4]), .seg(seg[i]));
        always_comb begin
            lit = mode_q ? raw_q[i] : {dp_q[i], seg[i]};
            if (blank_q[i] || (blink_q[i] && phase_q))
                lit = 8'h00;
        end
        assign out_d[8*i +: 8] = ACTIVE_LOW ? ~lit : lit;
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_DATA:  rd_data[4*N-1:0] = data_q;
            ADDR_DP:    rd_data[N-1:0]   = dp_q;
            ADDR_BLANK: rd_data[N-1:0]   = blank_q;
            ADDR_BLINK: rd_data[N-1:0]   = blink_q;
            ADDR_CTRL: begin
                rd_data[CTRL_MODE_BIT]  = mode_q;
                rd_data[CTRL_PHASE_BIT] = phase_q;
            end
            default: begin
                for (int i = 0; i < N; i++)
                    if (bus.address == 4'(ADDR_RAW_BASE + i))
                        rd_data[7:0] = raw_q[i];
            end
        endcase
    end

    assign bus.readdata = rd_data;
    assign out_port     = out_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            dp_q    <= '0;
            blank_q <= '1;
            blink_q <= '0;
            mode_q  <= 1'b0;
            raw_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            out_q   <= DARK;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            blank_q <= blank_d;
            blink_q <= blink_d;
            mode_q  <= mode_d;
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (6 digits, blink half-period 4,
// active-low pins). A digit-level model predicts out_port every cycle;
// directed steps add hand-computed literal expectations.
module tb_hex_display_ctrl;
    localparam int N   = 6;
    localparam int DIV = 4;

    logic           clk     = 1'b0;
    logic           reset_n = 1'b0;
    logic [N*8-1:0] out_port;

    hex_display_ctrl_if bus();

    hex_display_ctrl #(.NUM_DIGITS(N), .BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // ---------------- model: one record per digit ----------------
    logic [6:0]     glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]     m_nib   [N];
    bit             m_dp    [N];
    bit             m_blank [N];
    bit             m_blink [N];
    logic [7:0]     m_raw   [N];
    bit             m_mode, m_phase;
    int             m_cnt;
    logic [N*8-1:0] m_out;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_nib[i] = 0; m_dp[i] = 0; m_blank[i] = 1; m_blink[i] = 0; m_raw[i] = 0;
        end
        m_mode = 0; m_phase = 0; m_cnt = 0; m_out = '1;
    endfunction

    function automatic void m_write(int a, logic [31:0] d);
        for (int i = 0; i < N; i++) begin
            case (a)
                0: m_nib[i]   = d[4*i +: 4];
                1: m_dp[i]    = d[i];
                2: m_blank[i] = d[i];
                3: m_blink[i] = d[i];
                default: if (a == 8 + i) m_raw[i] = d[7:0];
            endcase
        end
        if (a == 4) m_mode = d[0];
    endfunction

    function automatic logic [31:0] m_read(int a);
        logic [31:0] r = 0;
        for (int i = 0; i < N; i++) begin
            case (a)
                0: r[4*i +: 4] = m_nib[i];
                1: r[i] = m_dp[i];
                2: r[i] = m_blank[i];
                3: r[i] = m_blink[i];
                default: if (a == 8 + i) r[7:0] = m_raw[i];
            endcase
        end
        if (a == 4) begin r[0] = m_mode; r[8] = m_phase; end
        return r;
    endfunction

    function automatic logic [N*8-1:0] m_display();
        logic [N*8-1:0] o;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            if (m_blank[i] || (m_blink[i] && m_phase)) b = 8'h00;
            else if (m_mode) b = m_raw[i];
            else b = {m_dp[i], glyph[m_nib[i]]};
            o[8*i +: 8] = ~b;
        end
        return o;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_reset();
        else begin
            bit rs;
            m_out = m_display();
            rs = 0;
            if (bus.chipselect && !bus.write_n) begin
                m_write(int'(bus.address), bus.writedata);
                rs = (bus.address == 4'd4) && bus.writedata[1];
            end
            if (rs) begin m_cnt = 0; m_phase = 0; end
            else if (m_cnt == DIV - 1) begin m_cnt = 0; m_phase = !m_phase; end
            else m_cnt++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk)
        if (check_en && reset_n) chk("out_port_vs_model", 64'(out_port), 64'(m_out));

    // ---------------- stimulus (all driven at negedge) ----------------
    task automatic wr(logic [3:0] a, logic [31:0] d, bit cs = 1'b1);
        bus.address = a; bus.writedata = d; bus.chipselect = cs; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(string name, logic [3:0] a, logic [31:0] exp);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1;
        chk(name, 64'(bus.readdata), 64'(exp));
        chk({name, "_model"}, 64'(bus.readdata), 64'(m_read(int'(a))));
        bus.chipselect = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        m_reset();
        #12;
        chk("reset_out_port", 64'(out_port), 64'(48'hFFFF_FFFF_FFFF));
        rd("reset_blank", 4'd2, 32'h3F);
        rd("reset_ctrl", 4'd4, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        check_en = 1'b1;
        idle(1);

        // hex decode and decimal point
        wr(4'd2, 32'h0);
        wr(4'd0, 32'h123456);
        idle(1);
        chk("hex_byte0_6", 64'(out_port[7:0]), 64'(8'h82));
        chk("hex_byte5_1", 64'(out_port[47:40]), 64'(8'hF9));
        chk("model_pin_byte0", 64'(m_out[7:0]), 64'(8'h82));
        wr(4'd1, 32'h01);
        idle(1);
        chk("dp_byte0", 64'(out_port[7:0]), 64'(8'h02));
        rd("dp_read", 4'd1, 32'h01);

        // raw mode
        wr(4'd4, 32'h1);
        wr(4'd8, 32'h80);
        idle(1);
        chk("raw_byte0", 64'(out_port[7:0]), 64'(8'h7F));
        chk("raw_byte1_dark", 64'(out_port[15:8]), 64'(8'hFF));
        chk("model_pin_raw", 64'(m_out[7:0]), 64'(8'h7F));
        wr(4'd4, 32'h0);
        idle(1);
        chk("hex_revert", 64'(out_port[7:0]), 64'(8'h02));
        rd("raw6_unmapped", 4'd14, 32'h0);
        rd("raw0_read", 4'd8, 32'h80);

        // blink, then restart while dark
        wr(4'd3, 32'h01);
        begin
            bit dark = 1'b0;
            for (int i = 0; i < 12 && !dark; i++) begin
                @(negedge clk);
                if (out_port[7:0] == 8'hFF) dark = 1'b1;
            end
            chk("blink_goes_dark", 64'(dark), 64'(1));
        end
        wr(4'd4, 32'h2);
        rd("restart_phase0", 4'd4, 32'h0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk(j <= 4 ? "restart_glyph_on" : "restart_glyph_off",
                64'(out_port[7:0]), j <= 4 ? 64'(8'h02) : 64'(8'hFF));
            chk("steady_digits", 64'(out_port[47:8]), 64'(40'hF9_A4_B0_99_92));
            if (j == 5) rd("phase_dark", 4'd4, 32'h100);
        end

        // ignored writes
        wr(4'd7, 32'hFFFF_FFFF);
        wr(4'd2, 32'h3F, 1'b0);
        rd("addr7_read", 4'd7, 32'h0);
        rd("blank_unchanged", 4'd2, 32'h0);
        rd("data_unchanged", 4'd0, 32'h123456);
        idle(2);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_dark", 64'(out_port), 64'(48'hFFFF_FFFF_FFFF));
        rd("reset_blank_again", 4'd2, 32'h3F);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);
        rd("prescale_from_zero_p0", 4'd4, 32'h0);
        idle(1);
        rd("prescale_from_zero_p1", 4'd4, 32'h100);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Avalon-MM slave driving up to 8 seven-segment digits; the next generation of the single-byte PIO hex output.
- Per-digit hex decode or raw segment mode, decimal points, blanking and blink with an internal prescaler.
- Sits between the Nios II data bus (via Platform Designer interconnect) and the board HEX pins.
- Output is registered, glitch-free, with parametrised polarity.

Parameters:
- NUM_DIGITS, 6, number of digits driven; legal range 1..8.
- BLINK_DIV, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); must be >= 2.
- ACTIVE_LOW, 1, 1 = segment/DP pins lit when 0 (DE10-Lite); 0 = lit when 1.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- address  input  4  register word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data, zero read latency (combinational)
- out_port  output  NUM_DIGITS*8  digit i in bits [8i+7:8i]; bit 7 = DP, bits 6:0 = segments g..a

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk.
- Write condition: chipselect && !write_n, sampled at posedge clk.
- Register map (N = NUM_DIGITS; bits above the field read 0):
  - 0 DATA: nibble i in [4i+3:4i], width 4N.
  - 1 DP: [N-1:0], DP on per digit.
  - 2 BLANK: [N-1:0], 1 = digit dark; reset value all ones.
  - 3 BLINK: [N-1:0], 1 = digit participates in blink.
  - 4 CTRL:
    - bit0 MODE: 0 = hex decode, 1 = raw.
    - bit1 RESTART: write-1 self-clearing, reads 0.
    - bit8 PHASE: read-only, current blink phase.
  - 8+i RAW_i (i < N): [7:0], raw segment byte for digit i.
- All other addresses, and RAW_i for i >= N, read 0; writes to them are ignored.
- Reset values: all registers 0 except BLANK = all ones. Prescaler count 0, phase 0, out_port all digits dark (all ones if ACTIVE_LOW).
- Hex decode table (active-high, bit0 = a):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Digit byte, active-high, before polarity:
  - MODE = 0: {DP[i], decode(nibble i)}.
  - MODE = 1: RAW_i (DP register ignored).
  - Forced to 0 if BLANK[i], or if (BLINK[i] && PHASE).
- out_port: registered. Value = digit bytes, inverted when ACTIVE_LOW.
- Latency: register write at edge k; out_port reflects it at edge k+1.
- Prescaler: count increments each cycle.
  - At count == BLINK_DIV-1, count wraps to 0 and PHASE toggles.
  - One PHASE half-period = BLINK_DIV cycles.
- RESTART write: at the same edge, count <= 0 and PHASE <= 0. Takes priority over a simultaneous wrap.
- Prescaler runs regardless of BLINK mask.
- Readdata: combinational from the current register state. A read in the same cycle as a write returns the old value.
- Reset mid-operation: out_port goes dark immediately (asynchronous); no partial state survives.

Decomposition:
- Package hex_display_pkg:
  - register address localparams (ADDR_DATA, ADDR_DP, ADDR_BLANK, ADDR_BLINK, ADDR_CTRL, ADDR_RAW_BASE)
  - CTRL bit index constants
  - 16-entry segment table constant
- Sub-module hex_seg_decode: combinational nibble to 7-bit active-high segments, instantiated NUM_DIGITS times via generate.

Test Plan:
- Reset (N=6, ACTIVE_LOW=1) -> out_port == 48'hFFFFFFFFFFFF; read addr 2 == 0x3F; read addr 4 == 0.
- Write BLANK=0, DATA=0x123456 -> one cycle later byte0 = 0x82 ('6'), byte5 = 0xF9 ('1'); then write DP=0x01 -> byte0 = 0x02.
- Write CTRL=1, RAW_0=0x80 -> byte0 = 0x7F. Then CTRL=0 -> byte0 reverts to decoded '6' with DP. Read addr 14 (RAW_6, N=6) == 0.
- BLINK_DIV=4, BLINK=0x01 -> byte0 alternates glyph / 0xFF every 4 cycles; bytes 1..5 steady; PHASE readback tracks. Write CTRL=2 mid-dark -> next cycle PHASE=0 and glyph shown for 4 cycles.
- Write addr 7 and write with chipselect=0 -> no register or out_port change; read addr 7 == 0.
- Assert reset_n during blink with display active -> out_port all ones without waiting for a clock edge; after release BLANK = 0x3F, count restarts from 0.
